// File: rtl/alu_logic_arbiter_if.sv
// Request/result bundle for alu_logic_arbiter: two requesters feed one bitwise-logic
// result register. The master modport is the requester/consumer side; slave is the block.
interface alu_logic_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic [15:0]      ops_done;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, ops_done
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, ops_done
  );
endinterface

// File: rtl/alu_logic_arbiter.sv
// Two-requester round-robin arbiter in front of a one-entry bitwise-logic result register
// (AND/OR/XOR/NOR), with pass-through refill and a wrapping completed-handshake counter.
module alu_logic_arbiter #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                reset,
  alu_logic_arbiter_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_OR  = 2'b01,
    OP_XOR = 2'b10,
    OP_NOR = 2'b11
  } op_t;

  state_t state;
  logic   ptr;
  logic   can_accept;
  logic   grant_id;
  logic   xfer;
  logic   handshake;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op_t'(op))
      OP_AND:  apply_op = a & b;
      OP_OR:   apply_op = a | b;
      OP_XOR:  apply_op = a ^ b;
      default: apply_op = ~(a | b);
    endcase
  endfunction

  // Ready never looks at operands or opcodes, so requesters may change them freely while waiting.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    can_accept     = 1'b0;
    grant_id       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (!reset) begin
      can_accept = (state == EMPTY) || bus.res_ready;
      if (bus.req0_valid && bus.req1_valid) grant_id = ptr;
      else                                  grant_id = bus.req1_valid;
      bus.req0_ready = can_accept && bus.req0_valid && !grant_id;
      bus.req1_ready = can_accept && bus.req1_valid &&  grant_id;
    end
  end

  assign xfer      = bus.req0_ready || bus.req1_ready;
  assign handshake = bus.res_valid && bus.res_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= EMPTY;
      ptr          <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_id   <= 1'b0;
      bus.ops_done <= 16'h0000;
    end else begin
      if (handshake) bus.ops_done <= bus.ops_done + 16'd1;
      if (xfer) begin
        state         <= FULL;
        bus.res_valid <= 1'b1;
        bus.res_id    <= grant_id;
        ptr           <= ~grant_id;
        bus.res_data  <= grant_id ? apply_op(bus.req1_op, bus.req1_a, bus.req1_b)
                                  : apply_op(bus.req0_op, bus.req0_a, bus.req0_b);
      end else if (handshake) begin
        state         <= EMPTY;
        bus.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Self-checking bench for alu_logic_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_alu_logic_arbiter;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_logic_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_logic_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model: one result slot, a turn pointer, a handshake counter.
  bit              m_full;
  logic [WIDTH-1:0] m_data;
  bit              m_id;
  bit              m_turn;
  int unsigned     m_handshakes;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_op(input logic [1:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      case (op)
        2'd0: r[i] = a[i] & b[i];
        2'd1: r[i] = a[i] | b[i];
        2'd2: r[i] = a[i] != b[i];
        default: r[i] = !(a[i] || b[i]);
      endcase
    end
    return r;
  endfunction

  // Who would be served right now, or -1 if nobody.
  function automatic int model_winner();
    if (reset) return -1;
    if (m_full && !bus.res_ready) return -1;
    if (bus.req0_valid && bus.req1_valid) return m_turn ? 1 : 0;
    if (bus.req0_valid) return 0;
    if (bus.req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    w = model_winner();
    if (reset) begin
      m_full = 0; m_data = '0; m_id = 0; m_turn = 0; m_handshakes = 0;
    end else begin
      if (m_full && bus.res_ready) m_handshakes++;
      if (w == 0) begin
        m_data = model_op(bus.req0_op, bus.req0_a, bus.req0_b);
        m_id = 0; m_turn = 1; m_full = 1;
      end else if (w == 1) begin
        m_data = model_op(bus.req1_op, bus.req1_a, bus.req1_b);
        m_id = 1; m_turn = 0; m_full = 1;
      end else if (m_full && bus.res_ready) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    int w;
    if (check_en) begin
      w = model_winner();
      check("model_req0_ready", 64'(bus.req0_ready), 64'(w == 0));
      check("model_req1_ready", 64'(bus.req1_ready), 64'(w == 1));
      check("model_res_valid", 64'(bus.res_valid), 64'(m_full));
      check("model_ops_done", 64'(bus.ops_done), 64'(m_handshakes % 65536));
      if (m_full) begin
        check("model_res_data", 64'(bus.res_data), 64'(m_data));
        check("model_res_id", 64'(bus.res_id), 64'(m_id));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = '0; bus.req1_b = '0;
    bus.res_ready = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    step();
    check_en = 1;
    step();
    @(negedge clk);
    check("reset_req0_ready", 64'(bus.req0_ready), 64'd0);
    check("reset_res_valid", 64'(bus.res_valid), 64'd0);
    check("reset_res_data", 64'(bus.res_data), 64'd0);
    check("reset_ops_done", 64'(bus.ops_done), 64'd0);

    // Single XOR op from requester 0.
    step();
    reset = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b10;
    bus.req0_a = 32'hFFFF0000; bus.req0_b = 32'h0F0F0F0F;
    bus.res_ready = 1;
    @(negedge clk);
    check("single_req0_ready", 64'(bus.req0_ready), 64'd1);
    step();
    bus.req0_valid = 0;
    @(negedge clk);
    check("single_res_valid", 64'(bus.res_valid), 64'd1);
    check("single_res_data", 64'(bus.res_data), 64'hF0F00F0F);
    check("single_res_id", 64'(bus.res_id), 64'd0);
    step();
    @(negedge clk);
    check("single_ops_done", 64'(bus.ops_done), 64'd1);
    check("single_drained", 64'(bus.res_valid), 64'd0);

    // NOR across the full width, top bit included.
    bus.req0_valid = 1; bus.req0_op = 2'b11;
    bus.req0_a = 32'h0; bus.req0_b = 32'h80000000;
    step();
    bus.req0_valid = 0;
    @(negedge clk);
    check("nor_res_data", 64'(bus.res_data), 64'h7FFFFFFF);
    step();

    // Contention from a fresh pointer.
    reset = 1;
    step();
    reset = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b01; bus.req0_a = 32'h1; bus.req0_b = 32'h2;
    bus.req1_valid = 1; bus.req1_op = 2'b00; bus.req1_a = 32'hF0F0F0F0; bus.req1_b = 32'hFF00FF00;
    bus.res_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("contend_grant0", 64'(bus.req0_ready), 64'(i % 2 == 0));
      check("contend_grant1", 64'(bus.req1_ready), 64'(i % 2 == 1));
      if (i > 0) check("contend_res_id", 64'(bus.res_id), 64'((i - 1) % 2));
      step();
    end

    // Backpressure: hold requester 1's AND result for five cycles.
    bus.res_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_ready0", 64'(bus.req0_ready), 64'd0);
      check("hold_ready1", 64'(bus.req1_ready), 64'd0);
      check("hold_res_data", 64'(bus.res_data), 64'hF000F000);
      check("hold_res_id", 64'(bus.res_id), 64'd1);
      step();
    end
    bus.res_ready = 1;
    @(negedge clk);
    check("hold_ptr_kept", 64'(bus.req0_ready), 64'd1);
    bus.req0_valid = 0;
    #1;
    check("refill_ready1", 64'(bus.req1_ready), 64'd1);
    step();
    @(negedge clk);
    check("refill_ops_done", 64'(bus.ops_done), 64'd4);
    check("refill_res_valid", 64'(bus.res_valid), 64'd1);

    // Reset while a result is held.
    bus.res_ready = 0;
    bus.req1_valid = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    @(negedge clk);
    check("midreset_res_valid", 64'(bus.res_valid), 64'd0);
    check("midreset_ops_done", 64'(bus.ops_done), 64'd0);
    bus.req0_valid = 1; bus.req1_valid = 1; bus.res_ready = 1;
    #1;
    check("midreset_grant0", 64'(bus.req0_ready), 64'd1);
    step();

    // Randomized traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      bus.req0_valid = ($urandom_range(0, 9) < 7);
      bus.req1_valid = ($urandom_range(0, 9) < 7);
      bus.req0_op = 2'($urandom); bus.req1_op = 2'($urandom);
      bus.req0_a = $urandom; bus.req0_b = $urandom;
      bus.req1_a = $urandom; bus.req1_b = $urandom;
      bus.res_ready = ($urandom_range(0, 9) < 6);
      step();
    end

    // Counter wrap: one handshake per cycle after the first fill.
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b10; bus.res_ready = 1;
    for (int i = 0; i < 65536; i++) begin
      bus.req0_a = $urandom; bus.req0_b = $urandom;
      step();
    end
    @(negedge clk);
    check("wrap_before", 64'(bus.ops_done), 64'hFFFF);
    step();
    @(negedge clk);
    check("wrap_after", 64'(bus.ops_done), 64'h0000);

    check_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_logic_arbiter.md
ALU_LOGIC_ARBITER -- requirements
Module: alu_logic_arbiter

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-007 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_op, req1_a, req1_b  same widths and meaning for requester 1.
REQ-009 res_valid  output  1  res_data/res_id hold a valid result.
REQ-010 res_ready  input  1  consumer accepts the result this cycle.
REQ-011 res_data  output  WIDTH  bitwise result over all WIDTH bits, bit 0 through bit WIDTH-1.
REQ-012 res_id  output  1  index of the requester that produced res_data.
REQ-013 ops_done  output  16  count of completed result handshakes.

Function
REQ-014 Two-state FSM SHALL be implemented: EMPTY (no result held), FULL (result held in output register).
REQ-015 A transfer on requester k SHALL occur when reqk_valid and reqk_ready are both 1 on a rising edge; a result handshake SHALL occur when res_valid and res_ready are both 1.
REQ-016 The block SHALL be able to accept a request when in EMPTY, or in FULL with res_ready=1 in the same cycle (pass-through refill, no bubble).
REQ-017 When able to accept, at most one reqk_ready SHALL be 1 per cycle; when unable to accept, both SHALL be 0.
REQ-018 Only one valid requester: that requester SHALL be granted.
REQ-019 Both valid: the requester indicated by a 1-bit priority pointer SHALL be granted.
REQ-020 After every transfer the pointer SHALL point to the requester not granted; with no transfer the pointer SHALL hold.
REQ-021 reqk_ready SHALL depend combinationally only on the valids, the pointer, the FSM state and res_ready, never on operands or opcodes.
REQ-022 On a transfer, the output register SHALL load the bitwise op of the granted operands, res_id SHALL load the granted index, and res_valid SHALL be 1 from the next cycle (latency one cycle).
REQ-023 Transitions: EMPTY+transfer -> FULL; FULL+handshake+no transfer -> EMPTY; FULL+handshake+transfer -> FULL with new result; FULL with res_ready=0 -> FULL with res_data/res_id stable.
REQ-024 res_valid SHALL be 1 exactly in FULL.
REQ-025 ops_done SHALL increment by 1 on each result handshake and SHALL wrap from 0xFFFF to 0x0000.
REQ-026 A requester SHALL be allowed to deassert valid or change operands while not granted; no starvation: with both continuously valid, grants SHALL strictly alternate.

Reset
REQ-027 reset=1 on a rising edge SHALL force: FSM EMPTY, res_valid=0, res_data=0, res_id=0, ops_done=0, pointer=requester 0; this SHALL take priority over any transfer or handshake in that cycle.
REQ-028 While reset=1, req0_ready and req1_ready SHALL be 0.
REQ-029 A held result discarded by reset mid-operation SHALL NOT be counted in ops_done.

Verification
REQ-030 Single op: reset released, req0 op=10 a=0xFFFF0000 b=0x0F0F0F0F, res_ready=1 -> req0_ready=1 that cycle, next cycle res_valid=1 res_data=0xF0F00F0F res_id=0, ops_done=1 after handshake.
REQ-031 Full-width check: op=11 (NOR) a=0 b=0x80000000 -> res_data=0x7FFFFFFF (bit 31 computed, not left undriven).
REQ-032 Contention: both valid every cycle, res_ready=1 -> grants alternate 0,1,0,1; res_id sequence 0,1,0,1 one cycle later; throughput one result per cycle.
REQ-033 Backpressure: result held with res_ready=0 for 5 cycles -> both readies 0, res_data/res_id stable, pointer unchanged; res_ready=1 with req1 valid -> handshake and new accept same cycle.
REQ-034 Reset mid-operation: FULL with res_ready=0, assert reset one cycle -> res_valid=0, ops_done=0, next grant with both valid goes to requester 0.
REQ-035 Wrap: drive 65536 handshakes -> ops_done returns to 0x0000.
